// File: rtl/regfile_write_buffer.sv
// Write-back buffer in front of the register file: queues write requests,
// drains one per cycle, and forwards the youngest pending value to readers.

// Forwarding for one read port: youngest live entry matching wins.
module regfile_write_buffer_fwd #(
  parameter int DEPTH = 4,
  parameter int PW    = 2,
  parameter int CW    = 3
) (
  input  logic [DEPTH-1:0][4:0]  entryReg,
  input  logic [DEPTH-1:0][31:0] entryData,
  input  logic [PW-1:0]          headPtr,
  input  logic [CW-1:0]          liveCount,
  input  logic [4:0]             readRegister,
  input  logic [31:0]            regReadData,
  output logic [31:0]            readData
);
  logic [PW-1:0] idx;

  // Walk from oldest to youngest so a later match overrides an earlier one.
  always_comb begin
    readData = regReadData;
    idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = headPtr + PW'(i);
      if ((CW'(i) < liveCount) && (entryReg[idx] == readRegister))
        readData = entryData[idx];
    end
    if (readRegister == 5'd0)
      readData = '0;
  end
endmodule

module regfile_write_buffer #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          InValid,
  output logic          InReady,
  input  logic [4:0]    InRegister,
  input  logic [31:0]   InData,
  input  logic          DrainEnable,
  output logic          RegWrite,
  output logic [4:0]    WriteRegister,
  output logic [31:0]   WriteData,
  input  logic [4:0]    ReadRegister1,
  input  logic [4:0]    ReadRegister2,
  input  logic [31:0]   RegReadData1,
  input  logic [31:0]   RegReadData2,
  output logic [31:0]   ReadData1,
  output logic [31:0]   ReadData2,
  output logic [CW-1:0] Count,
  output logic          Empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef struct packed {
    logic [4:0]  register;
    logic [31:0] data;
  } wbReq_t;

  wbReq_t inReq;
  logic [DEPTH-1:0][4:0]  entryReg;
  logic [DEPTH-1:0][31:0] entryData;
  logic [PW-1:0]          headPtr, tailPtr;
  logic [CW-1:0]          count, liveCount;
  logic                   accept, enq, deq;

  assign inReq   = '{register: InRegister, data: InData};
  assign InReady = !Reset && (count < DepthC);
  assign accept  = InValid && InReady;
  // Writes to r0 complete the handshake but are dropped: they can never matter.
  assign enq     = accept && (inReq.register != 5'd0);
  assign RegWrite      = !Reset && DrainEnable && (count != '0);
  assign deq           = RegWrite;
  assign WriteRegister = entryReg[headPtr];
  assign WriteData     = entryData[headPtr];
  assign Count         = count;
  assign Empty         = (count == '0);
  // Entries being discarded by reset must not be forwarded.
  assign liveCount     = Reset ? '0 : count;

  // Pointer and occupancy bookkeeping; reset discards everything pending.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
    end else begin
      if (enq) tailPtr <= tailPtr + PW'(1);
      if (deq) headPtr <= headPtr + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; validity is implied by the occupancy counter.
  always_ff @(posedge Clk) begin
    if (enq) begin
      entryReg[tailPtr]  <= inReq.register;
      entryData[tailPtr] <= inReq.data;
    end
  end

  logic [1:0][4:0]  readRegs;
  logic [1:0][31:0] regReads, readDatas;

  assign readRegs  = {ReadRegister2, ReadRegister1};
  assign regReads  = {RegReadData2, RegReadData1};
  assign ReadData1 = readDatas[0];
  assign ReadData2 = readDatas[1];

  for (genvar k = 0; k < 2; k++) begin : gFwd
    regfile_write_buffer_fwd #(.DEPTH(DEPTH), .PW(PW), .CW(CW)) uFwd (
      .entryReg     (entryReg),
      .entryData    (entryData),
      .headPtr      (headPtr),
      .liveCount    (liveCount),
      .readRegister (readRegs[k]),
      .regReadData  (regReads[k]),
      .readData     (readDatas[k])
    );
  end
endmodule

// File: tb/tb_regfile_write_buffer.sv
// Scoreboard bench: queue-level model of the buffer plus a register file.
module tb_regfile_write_buffer;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          Clk = 0;
  logic          Reset, InValid, InReady, DrainEnable, RegWrite, Empty;
  logic [4:0]    InRegister, WriteRegister, ReadRegister1, ReadRegister2;
  logic [31:0]   InData, WriteData, RegReadData1, RegReadData2, ReadData1, ReadData2;
  logic [CW-1:0] Count;

  always #5 Clk = ~Clk;

  regfile_write_buffer #(.DEPTH(DEPTH), .CW(CW)) dut (
    .Clk(Clk), .Reset(Reset), .InValid(InValid), .InReady(InReady),
    .InRegister(InRegister), .InData(InData), .DrainEnable(DrainEnable),
    .RegWrite(RegWrite), .WriteRegister(WriteRegister), .WriteData(WriteData),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .RegReadData1(RegReadData1), .RegReadData2(RegReadData2),
    .ReadData1(ReadData1), .ReadData2(ReadData2), .Count(Count), .Empty(Empty)
  );

  typedef struct { logic [4:0] r; logic [31:0] d; } wr_t;

  // Environment register file, written only by what the DUT drives out.
  logic [31:0] envRf [32];
  logic        junk;
  logic [31:0] junk1, junk2;
  assign RegReadData1 = junk ? junk1 : envRf[ReadRegister1];
  assign RegReadData2 = junk ? junk2 : envRf[ReadRegister2];
  always @(posedge Clk)
    if (RegWrite && WriteRegister != 0) envRf[WriteRegister] <= WriteData;

  // Reference model state.
  wr_t         pend[$];   // pending FIFO contents, oldest first
  wr_t         sbQ[$];    // expected regfile writes, in order
  logic [31:0] archRf [32];
  bit          chkOn = 0;
  int          nChecks = 0, nFails = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwdExp(logic [4:0] rr, logic [31:0] miss);
    logic [31:0] v;
    if (rr == 0) return 32'h0;
    v = miss;
    foreach (pend[i]) if (pend[i].r == rr) v = pend[i].d;
    return v;
  endfunction

  // Model state advance at each edge, from the inputs held over the cycle.
  always @(posedge Clk) begin
    if (Reset) begin
      pend.delete();
      sbQ.delete();
    end else begin
      bit doDrain, doAcc;
      doDrain = DrainEnable && pend.size() != 0;
      doAcc   = InValid && pend.size() < DEPTH;
      if (doDrain) begin
        archRf[pend[0].r] = pend[0].d;
        void'(pend.pop_front());
      end
      if (doAcc && InRegister != 0) begin
        pend.push_back('{InRegister, InData});
        sbQ.push_back('{InRegister, InData});
      end
    end
  end

  // Monitor: status/forwarding checks, and scoreboard pops on each regfile write.
  always @(negedge Clk) begin
    if (chkOn) begin
      logic expW;
      expW = !Reset && DrainEnable && pend.size() != 0;
      chk("InReady", 32'(InReady), 32'(!Reset && pend.size() < DEPTH));
      chk("RegWrite", 32'(RegWrite), 32'(expW));
      chk("Count", 32'(Count), 32'(pend.size()));
      chk("Empty", 32'(Empty), 32'(pend.size() == 0));
      if (!Reset) begin
        chk("ReadData1", ReadData1, fwdExp(ReadRegister1, junk ? junk1 : archRf[ReadRegister1]));
        chk("ReadData2", ReadData2, fwdExp(ReadRegister2, junk ? junk2 : archRf[ReadRegister2]));
      end
      if (RegWrite === 1'b1) begin
        if (sbQ.size() == 0) begin
          chk("unexpected_write", 32'(RegWrite), 32'h0);
        end else begin
          wr_t e;
          e = sbQ.pop_front();
          chk("WriteRegister", 32'(WriteRegister), 32'(e.r));
          chk("WriteData", WriteData, e.d);
        end
      end
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  task automatic req(logic [4:0] r, logic [31:0] d);
    InValid = 1; InRegister = r; InData = d;
  endtask

  initial begin
    foreach (envRf[i]) begin envRf[i] = 0; archRf[i] = 0; end
    Reset = 1; InValid = 0; InRegister = 0; InData = 0; DrainEnable = 0;
    ReadRegister1 = 0; ReadRegister2 = 0; junk = 0; junk1 = 0; junk2 = 0;
    step(2);
    chkOn = 1;
    step(1);
    Reset = 0;
    step(1);

    // Single write with immediate drain and forwarding.
    DrainEnable = 1; ReadRegister1 = 5;
    req(5, 32'hDEADBEEF); step(1);
    InValid = 0; step(3);

    // Fill with draining held off, then a rejected 5th request.
    DrainEnable = 0;
    for (int i = 1; i <= 4; i++) begin req(5'(i), 32'(i * 'h11)); step(1); end
    req(9, 32'h99); step(2);
    InValid = 0; DrainEnable = 1; ReadRegister1 = 3; ReadRegister2 = 4; step(6);

    // Duplicate destination: youngest value forwarded.
    DrainEnable = 0; ReadRegister1 = 7;
    req(7, 32'hA); step(1);
    req(7, 32'hB); step(1);
    InValid = 0; step(1);
    DrainEnable = 1; step(3);

    // Writes to r0 are swallowed; r0 reads zero regardless of the regfile.
    junk = 1; junk1 = 32'h12345678; junk2 = 32'hCAFEF00D; ReadRegister2 = 0;
    req(0, 32'hFFFFFFFF); step(1);
    InValid = 0; step(2);
    junk = 0;

    // Full buffer with request held: steady enqueue+drain and pointer wrap.
    DrainEnable = 0;
    for (int i = 0; i < DEPTH; i++) begin req(5'(10 + i), $urandom); step(1); end
    DrainEnable = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      req(5'(10 + (i % 6)), $urandom); ReadRegister1 = 5'(10 + (i % 6)); step(1);
    end
    InValid = 0; step(DEPTH + 2);

    // Reset with entries pending discards them.
    DrainEnable = 0;
    for (int i = 0; i < 3; i++) begin req(5'(20 + i), 32'hBAD0 + 32'(i)); step(1); end
    InValid = 0; ReadRegister1 = 20; ReadRegister2 = 21;
    Reset = 1; DrainEnable = 1; step(1);
    Reset = 0; step(3);

    // Randomized traffic with duplicates, junk regfile reads and rare resets.
    for (int i = 0; i < 400; i++) begin
      InValid       = 1'($urandom_range(0, 2) != 0);
      InRegister    = 5'($urandom_range(0, 7));
      InData        = $urandom;
      DrainEnable   = 1'($urandom_range(0, 2) != 0);
      ReadRegister1 = 5'($urandom_range(0, 7));
      ReadRegister2 = 5'($urandom_range(0, 7));
      junk          = ($urandom_range(0, 3) == 0);
      junk1         = $urandom;
      junk2         = $urandom;
      Reset         = ($urandom_range(0, 49) == 0);
      step(1);
    end
    Reset = 0; InValid = 0; DrainEnable = 1; junk = 0; step(DEPTH + 2);

    chk("sb_empty", 32'(sbQ.size()), 32'h0);
    for (int r = 0; r < 32; r++) chk($sformatf("regfile_r%0d", r), envRf[r], archRf[r]);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule

// File: doc/regfile_write_buffer.md
Name: regfile_write_buffer

Overview:
Write-back buffer sitting directly upstream of the MIPS register file (32 x 32-bit, reg 0 hard zero, 2 async read ports, 1 posedge write port). It accepts register write requests from the execute/memory stages over a valid/ready handshake and queues them in a small FIFO. It drains one entry per cycle into the register file's write port. Read-port outputs are forwarded so consumers always see the newest pending value for a register.

Parameters:
DEPTH, 4, number of FIFO entries; power of two, 2..16.
CW, 3, width of Count output; must be at least clog2(DEPTH+1).

Ports:
Clk  input  1  clock; all state updates on posedge.
Reset  input  1  synchronous, active-high reset.
InValid  input  1  upstream write request valid.
InReady  output  1  buffer can accept a request this cycle.
InRegister  input  5  destination register of request.
InData  input  32  data of request.
DrainEnable  input  1  permits draining head entry into regfile this cycle.
RegWrite  output  1  to regfile RegWrite.
WriteRegister  output  5  to regfile WriteRegister.
WriteData  output  32  to regfile WriteData.
ReadRegister1  input  5  read address 1; same value driven to regfile ReadRegister1.
ReadRegister2  input  5  read address 2; same value driven to regfile ReadRegister2.
RegReadData1  input  32  regfile ReadData1.
RegReadData2  input  32  regfile ReadData2.
ReadData1  output  32  forwarded read data 1.
ReadData2  output  32  forwarded read data 2.
Count  output  CW  number of valid entries.
Empty  output  1  Count == 0.

Behaviour:
- Storage: circular FIFO of DEPTH {register[4:0], data[31:0]} entries, head/tail pointers, occupancy counter. Pointers wrap modulo DEPTH.
- Reset (sync, posedge with Reset=1): Count=0, pointers=0, all entries invalid.
  - While Reset is high: InReady=0 and RegWrite=0.
  - After reset: RegWrite=0, Empty=1, InReady=1, Count=0.
  - Reset mid-operation discards all pending writes; none reach the regfile.
- Accept: handshake completes at posedge when InValid & InReady.
  - InReady = !Reset & (Count < DEPTH). No pass-through when full; a pop in the same cycle does not raise InReady.
  - Requests with InRegister == 0 are accepted (handshake completes) but not enqueued.
- Drain: combinational outputs.
  - RegWrite = !Reset & DrainEnable & (Count != 0).
  - WriteRegister and WriteData = head entry.
  - At a posedge with RegWrite=1 the regfile commits the head and the head pointer advances.
  - With DrainEnable=0 the FIFO holds and RegWrite=0.
- Simultaneous enqueue and drain: Count unchanged, both pointers advance; tail write and head read never alias, because the enqueue requires Count < DEPTH.
- Count update per edge: +1 enqueue only, -1 drain only, unchanged for both or neither. Empty = (Count == 0).
- Latency: a request accepted at edge N drives RegWrite during cycle N+1 if the FIFO was empty and DrainEnable=1. It is committed at edge N+1 and is readable from the regfile from cycle N+2.
- Ordering: drains are strictly in acceptance order, including duplicate destination registers.
- Forwarding (combinational, per port k):
  - If ReadRegisterk == 0: ReadDatak = 0.
  - Else if any valid entry matches ReadRegisterk: ReadDatak = data of the youngest matching entry (closest to tail), including the head being written this cycle.
  - Otherwise ReadDatak = RegReadDatak.
  - Ports are independent; both may hit the same entry.

Test Plan:
- Reset, then a single write: InRegister=5, InData=0xDEADBEEF, DrainEnable=1 -> InReady=1; next cycle RegWrite=1, WriteRegister=5, WriteData=0xDEADBEEF, ReadRegister1=5 gives ReadData1=0xDEADBEEF; following cycle Empty=1 and regfile reg5 reads 0xDEADBEEF.
- DrainEnable=0, push 4 writes (r1..r4 = 0x11,0x22,0x33,0x44) -> Count=4, InReady=0, a 5th request is not accepted; DrainEnable=1 -> RegWrite for r1,r2,r3,r4 on 4 consecutive cycles in order; Count falls 4,3,2,1,0.
- DrainEnable=0, push r7=0xA then r7=0xB, RegReadData1=0x0 -> ReadRegister1=7 gives 0xB; after draining the first entry still 0xB; after both drain, regfile r7=0xB.
- Request InRegister=0, InData=0xFFFFFFFF -> handshake completes, Count stays 0, RegWrite never asserts; ReadRegister2=0 gives ReadData2=0 regardless of RegReadData2.
- Full buffer (Count=4) with InValid held and DrainEnable=1 -> one pop per cycle, InReady reasserts only when Count<4, steady state enqueue+drain keeps Count constant; pointers wrap correctly over 3*DEPTH transfers with data intact.
- Reset asserted with Count=3 -> at that edge Count=0, Empty=1, RegWrite=0 during and after Reset, no pending entry is written to the regfile, forwarding returns RegReadData only.
